fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU; sits directly upstream of the IF/ID decode path.
- Owns the program counter and drives a synchronous-read instruction memory with 1-cycle read latency.
- Delivers {pc, pc+1, instr, valid} to decode. Honours stall from hazard logic and redirect (jump/branch/jumpmem target) from EX.
- Replaces the free-running PC/IF-ID pair with one registered, flushable stage.

Parameters:
- ADDR_W, 8, instruction-memory address width; imem_addr = low ADDR_W bits of PC.
- RESET_PC, 32'd0, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word presented when if_valid=0 (opcode 0000 = NOP).

Ports:
- clk, input, 1, single rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- stall, input, 1, hold stage; decode cannot accept this cycle.
- redirect_valid, input, 1, EX resolved a taken jump/branch; squash and refetch.
- redirect_target, input, 32, new PC when redirect_valid=1.
- imem_addr, output, ADDR_W, address sampled by instruction memory at the next rising edge (combinational).
- imem_rdata, input, 32, word at the address sampled on the previous edge.
- if_pc, output, 32, PC of the instruction in if_instr.
- if_pc_plus1, output, 32, if_pc + 1 (word-addressed PC).
- if_instr, output, 32, fetched instruction, or NOP_INSTR when invalid.
- if_valid, output, 1, if_instr is a real instruction.
- fetch_count, output, 32, saturating count of instructions delivered to decode.

Behaviour:
- Internal registers:
  - fetch_pc_q: next sequential address.
  - req_pc_q: address the memory sampled on the last edge.
  - req_valid_q: req_pc_q holds a live request.
- imem_addr mux:
  - redirect_valid=1: redirect_target[ADDR_W-1:0].
  - stall=1 (no redirect): req_pc_q[ADDR_W-1:0]. Re-reads the in-flight word so it is not lost.
  - Otherwise: fetch_pc_q[ADDR_W-1:0].
- Edge priority is reset > redirect > stall > advance.
- reset:
  - fetch_pc_q=RESET_PC, req_pc_q=RESET_PC, req_valid_q=0.
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus1=0, fetch_count=0.
- redirect:
  - req_pc_q<=redirect_target, req_valid_q<=1, fetch_pc_q<=redirect_target+1.
  - if_valid<=0, if_instr<=NOP_INSTR, if_pc/if_pc_plus1 hold.
  - Wins over a simultaneous stall.
- stall (no redirect):
  - All registers hold, including outputs and fetch_count.
  - Memory re-samples req_pc_q, so imem_rdata is still correct after release.
- advance:
  - If req_valid_q=1: if_pc<=req_pc_q, if_pc_plus1<=req_pc_q+1, if_instr<=imem_rdata, if_valid<=1, fetch_count<=fetch_count+1 (saturates at 32'hFFFF_FFFF).
  - If req_valid_q=0: if_valid<=0, if_instr<=NOP_INSTR.
  - Then req_pc_q<=fetch_pc_q, req_valid_q<=1, fetch_pc_q<=fetch_pc_q+1.
- Latency:
  - First valid output appears after the 2nd rising edge following reset deassertion.
  - A redirect target appears as if_pc after the 2nd edge following the redirect cycle, with exactly one bubble (if_valid=0) in between.
- Arithmetic:
  - PCs are 32-bit, increment modulo 2^32, no carry out.
  - imem_addr wraps at 2^ADDR_W while if_pc keeps counting (PC 255 -> 256 gives imem_addr 0).
- Reset mid-operation discards the in-flight request and output; the next fetch is RESET_PC.
- No combinational path from imem_rdata to any output. Only imem_addr is combinational, from stall/redirect.

Decomposition:
- Shared package: opcode constants (NOP/JUMP/BRZ/BRN/JUMPMEM/...) and NOP_INSTR, also used by control and immGen.
- No sub-module is warranted. PC incrementer, address mux, and saturating counter stay inline; the stage is one register bank plus one mux.

Test Plan:
- Reset release, RESET_PC=0, memory model mem[i]=32'hA000_0000+i -> edge 1: if_valid=0; edges 2,3,4: if_pc=0,1,2, if_instr=A000_0000..A000_0002, if_pc_plus1=pc+1, fetch_count=1,2,3.
- Stall held 3 cycles while if_pc=5 -> if_pc/if_instr/fetch_count frozen, imem_addr=6. First edge after release: if_pc=6, then 7. No skip, no duplicate.
- Redirect to 17 while if_pc=10 -> next edge: if_valid=0, if_instr=0. Following edge: if_pc=17, if_instr=mem[17], then 18.
- Redirect to 40 and stall asserted together -> redirect wins: imem_addr=40 that cycle, if_pc=40 two edges later.
- reset asserted one cycle at if_pc=12 -> next edge: if_valid=0, fetch_count=0. Sequence restarts at if_pc=0 with no stale instruction emitted.
- Run through PC 255 with ADDR_W=8 -> if_pc=256 with if_instr=mem[0], imem_addr wraps to 0/1. Preload fetch_count near max -> saturates at FFFF_FFFF.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: opcode encodings, the NOP instruction word and
// small PC helpers used by fetch, control and immediate generation.
package fetch_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 4;

  // Opcode lives in the top nibble of the instruction word.
  localparam logic [OP_W-1:0] OP_NOP     = 4'b0000;
  localparam logic [OP_W-1:0] OP_JUMP    = 4'b0001;
  localparam logic [OP_W-1:0] OP_BRZ     = 4'b0010;
  localparam logic [OP_W-1:0] OP_BRN     = 4'b0011;
  localparam logic [OP_W-1:0] OP_JUMPMEM = 4'b0100;
  localparam logic [OP_W-1:0] OP_LOAD    = 4'b0101;
  localparam logic [OP_W-1:0] OP_STORE   = 4'b0110;
  localparam logic [OP_W-1:0] OP_ALU     = 4'b0111;

  // All-zero word decodes as opcode 0000, i.e. a NOP.
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0000;

  localparam logic [XLEN-1:0] COUNT_MAX  = 32'hFFFF_FFFF;

  // Word-addressed PC increment, modulo 2^32.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd1;
  endfunction

  // Saturating increment for event counters.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] cnt);
    return (cnt == COUNT_MAX) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency
// synchronous instruction memory and presents one registered,
// flushable {pc, pc+1, instr, valid} bundle to decode.
//
// Handshake: decode accepts the bundle on every edge where stall=0;
// while stall=1 the whole stage holds and the memory re-reads the
// in-flight address so the returned word is still correct on release.
// A redirect squashes the in-flight fetch (one bubble) and restarts at
// the target; it takes priority over stall, and reset over both.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] NOP_INSTR   = fetch_stage_pkg::NOP_INSTR,
  parameter logic [31:0] COUNT_RESET = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus1,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic [31:0]       fetch_count
);

  logic [31:0] fetch_pc_q;   // next sequential address to request
  logic [31:0] req_pc_q;     // address the memory sampled on the last edge
  logic        req_valid_q;  // req_pc_q is a live request

  // Address presented to memory: redirect target, in-flight re-read on stall, or next sequential.
  always_comb begin
    imem_addr = fetch_pc_q[ADDR_W-1:0];
    if (redirect_valid) begin
      imem_addr = redirect_target[ADDR_W-1:0];
    end else if (stall) begin
      imem_addr = req_pc_q[ADDR_W-1:0];
    end
  end

  // Stage register bank: reset > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= 32'd0;
      if_pc_plus1 <= 32'd0;
      fetch_count <= COUNT_RESET;
    end else if (redirect_valid) begin
      // Squash the in-flight word; the target is being read this edge.
      req_pc_q    <= redirect_target;
      req_valid_q <= 1'b1;
      fetch_pc_q  <= pc_inc(redirect_target);
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
    end else if (!stall) begin
      if (req_valid_q) begin
        if_pc       <= req_pc_q;
        if_pc_plus1 <= pc_inc(req_pc_q);
        if_instr    <= imem_rdata;
        if_valid    <= 1'b1;
        fetch_count <= sat_inc(fetch_count);
      end else begin
        if_valid    <= 1'b0;
        if_instr    <= NOP_INSTR;
      end
      req_pc_q    <= fetch_pc_q;
      req_valid_q <= 1'b1;
      fetch_pc_q  <= pc_inc(fetch_pc_q);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset latency, stall hold, redirect
// bubble, redirect-vs-stall priority, mid-run reset, PC/address wrap and
// counter saturation (second instance starting near the counter limit).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc, if_pc_plus1, if_instr, fetch_count;
  logic        if_valid;

  // saturation instance signals
  logic [7:0]  sat_addr;
  logic [31:0] sat_rdata;
  logic [31:0] sat_pc, sat_pc_plus1, sat_instr, sat_count;
  logic        sat_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(8), .RESET_PC(32'd0), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_pc_plus1(if_pc_plus1), .if_instr(if_instr),
    .if_valid(if_valid), .fetch_count(fetch_count)
  );

  fetch_stage #(.ADDR_W(8), .COUNT_RESET(32'hFFFF_FFFD)) u_sat (
    .clk(clk), .reset(reset), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_target(32'd0),
    .imem_addr(sat_addr), .imem_rdata(sat_rdata),
    .if_pc(sat_pc), .if_pc_plus1(sat_pc_plus1), .if_instr(sat_instr),
    .if_valid(sat_valid), .fetch_count(sat_count)
  );

  // Memory model: mem[i] = A000_0000 + i, one-cycle synchronous read.
  always @(posedge clk) begin
    imem_rdata <= 32'hA000_0000 + {24'd0, imem_addr};
    sat_rdata  <= 32'hA000_0000 + {24'd0, sat_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    check({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
    check({tag, ".pc"},    if_pc, pc);
    check({tag, ".pc1"},   if_pc_plus1, pc + 32'd1);
    check({tag, ".instr"}, if_instr, 32'hA000_0000 + {24'd0, pc[7:0]});
    check({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    int cnt;
    int guard;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    step(); step();
    check("rst.valid", {31'd0, if_valid}, 32'd0);
    check("rst.instr", if_instr, 32'd0);
    check("rst.pc", if_pc, 32'd0);
    check("rst.pc1", if_pc_plus1, 32'd0);
    check("rst.count", fetch_count, 32'd0);

    // Reset release: one bubble, then pc 0,1,2...
    reset = 1'b0;
    step();
    check("e1.valid", {31'd0, if_valid}, 32'd0);
    check("e1.instr", if_instr, 32'd0);
    cnt = 0;
    for (int p = 0; p <= 5; p++) begin
      step();
      cnt++;
      check_out("seq", p, cnt);
      if (p == 1) check("sat.e3", sat_count, 32'hFFFF_FFFF);
      if (p == 2) check("sat.e4", sat_count, 32'hFFFF_FFFF);
      if (p == 3) check("sat.valid", {31'd0, sat_valid}, 32'd1);
    end

    // Stall three cycles at pc 5: frozen, memory re-reads pc 6.
    stall = 1'b1;
    #1 check("stall.addr", {24'd0, imem_addr}, 32'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 32'd5, cnt);
      check("stall.addr_h", {24'd0, imem_addr}, 32'd6);
    end
    stall = 1'b0;
    step(); cnt++; check_out("rel6", 32'd6, cnt);
    step(); cnt++; check_out("rel7", 32'd7, cnt);
    step(); cnt++;
    step(); cnt++;
    step(); cnt++; check_out("pre10", 32'd10, cnt);

    // Redirect to 17 at pc 10: one bubble, then 17, 18.
    redirect_valid = 1'b1; redirect_target = 32'd17;
    #1 check("redir.addr", {24'd0, imem_addr}, 32'd17);
    step();
    redirect_valid = 1'b0;
    check("redir.bub.valid", {31'd0, if_valid}, 32'd0);
    check("redir.bub.instr", if_instr, 32'd0);
    check("redir.bub.pc", if_pc, 32'd10);
    check("redir.bub.count", fetch_count, cnt);
    step(); cnt++; check_out("redir17", 32'd17, cnt);
    step(); cnt++; check_out("redir18", 32'd18, cnt);

    // Redirect and stall together: redirect wins.
    redirect_valid = 1'b1; redirect_target = 32'd40; stall = 1'b1;
    #1 check("rs.addr", {24'd0, imem_addr}, 32'd40);
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check("rs.bub.valid", {31'd0, if_valid}, 32'd0);
    step(); cnt++; check_out("rs40", 32'd40, cnt);
    step(); cnt++; check_out("rs41", 32'd41, cnt);

    // Mid-run reset: discard in-flight work, restart at 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst.valid", {31'd0, if_valid}, 32'd0);
    check("mrst.count", fetch_count, 32'd0);
    check("mrst.pc", if_pc, 32'd0);
    step();
    check("mrst.e1.valid", {31'd0, if_valid}, 32'd0);
    check("mrst.e1.count", fetch_count, 32'd0);
    cnt = 0;
    step(); cnt++; check_out("mrst0", 32'd0, cnt);
    step(); cnt++; check_out("mrst1", 32'd1, cnt);

    // Run to pc 255, then cross into 256 with memory address wrap.
    guard = 0;
    while (if_pc != 32'd255 && guard < 400) begin
      step(); cnt++; guard++;
    end
    check("wrap.reach", if_pc, 32'd255);
    check("wrap.addr", {24'd0, imem_addr}, 32'd1);
    step(); cnt++;
    check_out("wrap256", 32'd256, cnt);
    check("wrap.instr0", if_instr, 32'hA000_0000);
    check("wrap.addr2", {24'd0, imem_addr}, 32'd2);
    step(); cnt++;
    check_out("wrap257", 32'd257, cnt);
    check("sat.hold", sat_count, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
